// File: rtl/bytes_to_word_pkg.sv
// rtl/bytes_to_word_pkg.sv - shared types and big-endian lane helpers for bytes_to_word
package bytes_to_word_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RMW_RD,
        ST_RMW_WR,
        ST_FULL_WR,
        ST_RD_WAIT
    } state_t;

    // Byte offset k occupies word bits [31-8k -: 8].
    function automatic logic [4:0] lane_hi(input logic [1:0] k);
        return {~k, 3'b111};
    endfunction

    function automatic logic [7:0] get_byte(input logic [31:0] word, input logic [1:0] k);
        return word[lane_hi(k) -: 8];
    endfunction

    function automatic logic [31:0] insert_byte(input logic [31:0] word, input logic [1:0] k,
                                                input logic [7:0] b);
        logic [31:0] r;
        r = word;
        r[lane_hi(k) -: 8] = b;
        return r;
    endfunction

    // Buffered lanes win over the memory word.
    function automatic logic [31:0] merge_word(input logic [31:0] buf_word, input logic [3:0] mask,
                                               input logic [31:0] mem_word);
        logic [31:0] r;
        r = mem_word;
        r = mask[0] ? insert_byte(r, 2'd0, get_byte(buf_word, 2'd0)) : r;
        r = mask[1] ? insert_byte(r, 2'd1, get_byte(buf_word, 2'd1)) : r;
        r = mask[2] ? insert_byte(r, 2'd2, get_byte(buf_word, 2'd2)) : r;
        r = mask[3] ? insert_byte(r, 2'd3, get_byte(buf_word, 2'd3)) : r;
        return r;
    endfunction

endpackage

// File: rtl/bytes_to_word.sv
// rtl/bytes_to_word.sv - byte-wide target to word-wide initiator with write-combining buffer
module bytes_to_word
    import bytes_to_word_pkg::*;
#(
    parameter int word_read_cycles = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flush,
    output logic        busy,
    input  logic [31:0] byte_addr,
    input  logic        byte_wr,
    input  logic        byte_rd,
    input  logic [7:0]  byte_wr_data,
    output logic [7:0]  byte_rd_data,
    output logic [31:0] word_addr,
    output logic        word_wr,
    output logic        word_rd,
    output logic [31:0] word_wr_data,
    input  logic [31:0] word_rd_data
);
    localparam int CNT_W = $clog2(word_read_cycles + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(word_read_cycles);

    state_t           state, state_nxt;
    logic [31:0]      wbuf;
    logic [3:0]       wmask;
    logic [29:0]      waddr;
    logic             pend_valid;
    logic [31:0]      pend_addr;
    logic [7:0]       pend_data;
    logic [1:0]       rd_lane;
    logic [CNT_W-1:0] cnt;

    logic        idle, wr_acc, rd_acc, same_word, cnt_done;
    logic [3:0]  merged_mask;
    logic [31:0] merged_buf;
    logic [7:0]  rd_byte;

    always_comb begin
        idle        = (state == ST_IDLE);
        wr_acc      = idle && byte_wr;
        rd_acc      = idle && byte_rd && !byte_wr;
        same_word   = (wmask == 4'h0) || (byte_addr[31:2] == waddr);
        merged_mask = wmask | (4'b0001 << byte_addr[1:0]);
        merged_buf  = insert_byte(wbuf, byte_addr[1:0], byte_wr_data);
        cnt_done    = (cnt == '0);
        // word_addr still holds the address of the read in flight.
        rd_byte     = (wmask[rd_lane] && (waddr == word_addr[31:2])) ? get_byte(wbuf, rd_lane)
                                                                     : get_byte(word_rd_data, rd_lane);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (wr_acc && same_word) begin
                    if (merged_mask == 4'hF) state_nxt = ST_FULL_WR;
                    else if (flush)          state_nxt = ST_RMW_RD;
                end else if (wr_acc) begin
                    state_nxt = ST_RMW_RD;
                end else if (rd_acc) begin
                    state_nxt = ST_RD_WAIT;
                end else if (flush && (wmask != 4'h0)) begin
                    state_nxt = ST_RMW_RD;
                end
            end
            ST_RMW_RD:  if (cnt_done) state_nxt = ST_RMW_WR;
            ST_RMW_WR:  state_nxt = ST_IDLE;
            ST_FULL_WR: state_nxt = ST_IDLE;
            ST_RD_WAIT: if (cnt_done) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = !idle;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wbuf         <= '0;
            wmask        <= '0;
            waddr        <= '0;
            pend_valid   <= 1'b0;
            pend_addr    <= '0;
            pend_data    <= '0;
            rd_lane      <= '0;
            cnt          <= '0;
            word_addr    <= '0;
            word_wr      <= 1'b0;
            word_rd      <= 1'b0;
            word_wr_data <= '0;
            byte_rd_data <= '0;
        end else begin
            word_wr <= 1'b0;
            word_rd <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (wr_acc && same_word) begin
                        wbuf  <= merged_buf;
                        wmask <= merged_mask;
                        waddr <= byte_addr[31:2];
                        if (merged_mask == 4'hF) begin
                            word_wr      <= 1'b1;
                            word_addr    <= {byte_addr[31:2], 2'b00};
                            word_wr_data <= merged_buf;
                        end else if (flush) begin
                            word_rd   <= 1'b1;
                            word_addr <= {byte_addr[31:2], 2'b00};
                            cnt       <= CNT_LOAD;
                        end
                    end else if (wr_acc) begin
                        pend_valid <= 1'b1;
                        pend_addr  <= byte_addr;
                        pend_data  <= byte_wr_data;
                        word_rd    <= 1'b1;
                        word_addr  <= {waddr, 2'b00};
                        cnt        <= CNT_LOAD;
                    end else if (rd_acc) begin
                        rd_lane   <= byte_addr[1:0];
                        word_rd   <= 1'b1;
                        word_addr <= {byte_addr[31:2], 2'b00};
                        cnt       <= CNT_LOAD;
                    end else if (flush && (wmask != 4'h0)) begin
                        word_rd   <= 1'b1;
                        word_addr <= {waddr, 2'b00};
                        cnt       <= CNT_LOAD;
                    end
                end
                ST_RMW_RD: begin
                    if (cnt_done) begin
                        word_wr      <= 1'b1;
                        word_wr_data <= merge_word(wbuf, wmask, word_rd_data);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_RMW_WR: begin
                    // A displaced byte write becomes the sole occupant of the emptied buffer.
                    if (pend_valid) begin
                        wbuf       <= insert_byte(32'h0, pend_addr[1:0], pend_data);
                        wmask      <= 4'b0001 << pend_addr[1:0];
                        waddr      <= pend_addr[31:2];
                        pend_valid <= 1'b0;
                    end else begin
                        wmask <= 4'h0;
                    end
                end
                ST_FULL_WR: wmask <= 4'h0;
                ST_RD_WAIT: begin
                    if (cnt_done) byte_rd_data <= rd_byte;
                    else          cnt <= cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bytes_to_word.sv
// tb/tb_bytes_to_word.sv - scoreboard bench for bytes_to_word over N = 1, 2, 5
module tb_bytes_to_word;

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
    } wtxn_t;

    typedef struct {
        int         due;
        logic [7:0] val;
    } rexp_t;

    logic clk;
    int   checks = 0;
    int   failures = 0;
    int   done_cnt = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        checks++;
        failures++;
        $display("FAIL %s: %s", name, what);
    endtask

    function automatic logic [31:0] init_word(input logic [29:0] w);
        return {w[15:0] ^ 16'hA5C3, ~w[15:0]};
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g_n
        localparam int N = (gi == 0) ? 1 : ((gi == 1) ? 2 : 5);

        logic        reset_n, flush, busy, byte_wr, byte_rd, word_wr, word_rd;
        logic [31:0] byte_addr, word_addr, word_wr_data, word_rd_data;
        logic [7:0]  byte_wr_data, byte_rd_data;

        bytes_to_word #(.word_read_cycles(N)) dut (
            .clk          (clk),
            .reset_n      (reset_n),
            .flush        (flush),
            .busy         (busy),
            .byte_addr    (byte_addr),
            .byte_wr      (byte_wr),
            .byte_rd      (byte_rd),
            .byte_wr_data (byte_wr_data),
            .byte_rd_data (byte_rd_data),
            .word_addr    (word_addr),
            .word_wr      (word_wr),
            .word_rd      (word_rd),
            .word_wr_data (word_wr_data),
            .word_rd_data (word_rd_data)
        );

        int          cyc = 0;
        logic [31:0] dut_mem [logic [29:0]];
        logic [31:0] ref_mem [logic [29:0]];
        logic [31:0] dl [1:N+1];
        wtxn_t       exp_q [$];
        rexp_t       rd_q [$];
        int          n_wr = 0, n_rd = 0;
        logic [31:0] last_wr_addr = '0, last_wr_data = '0, last_rd_addr = '0;
        logic [7:0]  rb_data [4];
        bit          rb_valid [4];
        logic [29:0] rb_addr;

        assign word_rd_data = dl[N+1];

        always @(posedge clk) cyc <= cyc + 1;

        // Word-side memory with fixed read latency, plus the scoreboard monitor.
        always @(negedge clk) begin
            wtxn_t e;
            rexp_t r;
            for (int i = N + 1; i >= 2; i--) dl[i] = dl[i-1];
            if (word_rd)
                dl[1] = dut_mem.exists(word_addr[31:2]) ? dut_mem[word_addr[31:2]] : init_word(word_addr[31:2]);
            else
                dl[1] = $urandom;
            if (word_rd) begin
                n_rd++;
                last_rd_addr = word_addr;
                if (exp_q.size() == 0) fail_now($sformatf("N%0d_word_rd", N), $sformatf("got rd %h expected none", word_addr));
                else begin
                    e = exp_q.pop_front();
                    if (e.is_wr) fail_now($sformatf("N%0d_word_rd", N), $sformatf("got rd %h expected wr %h", word_addr, e.addr));
                    else chk($sformatf("N%0d_word_rd_addr", N), word_addr, e.addr);
                end
            end
            if (word_wr) begin
                n_wr++;
                last_wr_addr = word_addr;
                last_wr_data = word_wr_data;
                dut_mem[word_addr[31:2]] = word_wr_data;
                if (exp_q.size() == 0) fail_now($sformatf("N%0d_word_wr", N), $sformatf("got wr %h expected none", word_addr));
                else begin
                    e = exp_q.pop_front();
                    if (!e.is_wr) fail_now($sformatf("N%0d_word_wr", N), $sformatf("got wr %h expected rd %h", word_addr, e.addr));
                    else begin
                        chk($sformatf("N%0d_word_wr_addr", N), word_addr, e.addr);
                        chk($sformatf("N%0d_word_wr_data", N), word_wr_data, e.data);
                    end
                end
            end
            if (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
                r = rd_q.pop_front();
                chk($sformatf("N%0d_byte_rd_data_at_%0d", N, r.due), {24'h0, byte_rd_data}, {24'h0, r.val});
            end
        end

        function automatic logic [31:0] ref_get(input logic [29:0] w);
            return ref_mem.exists(w) ? ref_mem[w] : init_word(w);
        endfunction

        function automatic bit rb_empty();
            return !(rb_valid[0] || rb_valid[1] || rb_valid[2] || rb_valid[3]);
        endfunction

        task automatic preload(input logic [31:0] a, input logic [31:0] v);
            ref_mem[a[31:2]] = v;
            dut_mem[a[31:2]] = v;
        endtask

        // Reference: write buffered lanes over memory, byte 0 is most significant.
        task automatic ref_rmw();
            logic [31:0] m, merged;
            logic [7:0]  b;
            m = ref_get(rb_addr);
            merged = 0;
            exp_q.push_back('{is_wr: 1'b0, addr: {rb_addr, 2'b00}, data: 32'h0});
            for (int k = 0; k < 4; k++) begin
                b = rb_valid[k] ? rb_data[k] : 8'((m >> (8 * (3 - k))) & 32'hFF);
                merged = (merged << 8) | {24'h0, b};
            end
            exp_q.push_back('{is_wr: 1'b1, addr: {rb_addr, 2'b00}, data: merged});
            ref_mem[rb_addr] = merged;
            for (int k = 0; k < 4; k++) rb_valid[k] = 0;
        endtask

        task automatic ref_write(input logic [31:0] a, input logic [7:0] d, input bit fl, output int be);
            logic [1:0] k;
            logic [31:0] full;
            k = a[1:0];
            be = 0;
            if (rb_empty() || a[31:2] == rb_addr) begin
                rb_addr = a[31:2];
                rb_valid[k] = 1;
                rb_data[k] = d;
                if (rb_valid[0] && rb_valid[1] && rb_valid[2] && rb_valid[3]) begin
                    full = {rb_data[0], rb_data[1], rb_data[2], rb_data[3]};
                    exp_q.push_back('{is_wr: 1'b1, addr: {rb_addr, 2'b00}, data: full});
                    ref_mem[rb_addr] = full;
                    for (int j = 0; j < 4; j++) rb_valid[j] = 0;
                    be = 1;
                end else if (fl) begin
                    ref_rmw();
                    be = N + 2;
                end
            end else begin
                ref_rmw();
                rb_addr = a[31:2];
                rb_valid[k] = 1;
                rb_data[k] = d;
                be = N + 2;
            end
        endtask

        task automatic issue_wait(input int be, input bit poke);
            int n;
            @(posedge clk); #1;
            byte_wr = 0; byte_rd = 0; flush = 0;
            if (poke && be > 0) begin
                byte_wr = 1; byte_rd = 1;
                byte_addr = $urandom; byte_wr_data = $urandom;
            end
            n = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (i == 1) begin byte_wr = 0; byte_rd = 0; end
                if (!busy) break;
                n++;
            end
            byte_wr = 0; byte_rd = 0;
            chk($sformatf("N%0d_busy_cycles", N), n, be);
        endtask

        task automatic do_write(input logic [31:0] a, input logic [7:0] d, input bit fl, input bit also_rd);
            int be;
            @(posedge clk); #1;
            byte_addr = a; byte_wr_data = d; byte_wr = 1; byte_rd = also_rd; flush = fl;
            ref_write(a, d, fl, be);
            issue_wait(be, $urandom_range(0, 3) == 0);
        endtask

        task automatic do_read(input logic [31:0] a, output logic [7:0] v);
            logic [31:0] m;
            logic [7:0]  e;
            @(posedge clk); #1;
            byte_addr = a; byte_rd = 1;
            exp_q.push_back('{is_wr: 1'b0, addr: {a[31:2], 2'b00}, data: 32'h0});
            m = ref_get(a[31:2]);
            e = (rb_valid[a[1:0]] && rb_addr == a[31:2]) ? rb_data[a[1:0]] : 8'((m >> (8 * (3 - a[1:0]))) & 32'hFF);
            rd_q.push_back('{due: cyc + N + 2, val: e});
            issue_wait(N + 1, $urandom_range(0, 3) == 0);
            v = byte_rd_data;
        endtask

        task automatic do_flush();
            int be;
            @(posedge clk); #1;
            flush = 1;
            be = 0;
            if (!rb_empty()) begin
                ref_rmw();
                be = N + 2;
            end
            issue_wait(be, 1'b0);
        endtask

        task automatic chk_reset_outputs(input string tag);
            chk($sformatf("N%0d_%s_word_wr", N, tag), {31'h0, word_wr}, 32'h0);
            chk($sformatf("N%0d_%s_word_rd", N, tag), {31'h0, word_rd}, 32'h0);
            chk($sformatf("N%0d_%s_word_addr", N, tag), word_addr, 32'h0);
            chk($sformatf("N%0d_%s_word_wr_data", N, tag), word_wr_data, 32'h0);
            chk($sformatf("N%0d_%s_byte_rd_data", N, tag), {24'h0, byte_rd_data}, 32'h0);
            chk($sformatf("N%0d_%s_busy", N, tag), {31'h0, busy}, 32'h0);
        endtask

        initial begin
            int          w0, r0, op;
            logic [7:0]  v;
            logic [31:0] a, iw;
            reset_n = 0; flush = 0; byte_wr = 0; byte_rd = 0; byte_addr = 0; byte_wr_data = 0;
            for (int k = 0; k < 4; k++) rb_valid[k] = 0;
            rb_addr = 0;
            for (int i = 1; i <= N + 1; i++) dl[i] = 0;
            repeat (2) @(posedge clk);
            @(negedge clk);
            chk_reset_outputs("reset");
            @(posedge clk); #1;
            reset_n = 1;

            w0 = n_wr; r0 = n_rd;
            do_write(32'h100, 8'h11, 0, 0);
            do_write(32'h101, 8'h22, 0, 0);
            do_write(32'h102, 8'h33, 0, 0);
            do_write(32'h103, 8'h44, 0, 0);
            chk($sformatf("N%0d_full_wr_count", N), n_wr - w0, 1);
            chk($sformatf("N%0d_full_rd_count", N), n_rd - r0, 0);
            chk($sformatf("N%0d_full_wr_addr", N), last_wr_addr, 32'h100);
            chk($sformatf("N%0d_full_wr_data", N), last_wr_data, 32'h11223344);

            preload(32'h200, 32'hAABBCCDD);
            do_write(32'h202, 8'h55, 0, 0);
            do_flush();
            chk($sformatf("N%0d_flush_rd_addr", N), last_rd_addr, 32'h200);
            chk($sformatf("N%0d_flush_wr_addr", N), last_wr_addr, 32'h200);
            chk($sformatf("N%0d_flush_wr_data", N), last_wr_data, 32'hAABB55DD);

            preload(32'h300, 32'h10203040);
            do_write(32'h301, 8'h66, 0, 0);
            do_write(32'h400, 8'h77, 0, 0);
            chk($sformatf("N%0d_evict_rd_addr", N), last_rd_addr, 32'h300);
            chk($sformatf("N%0d_evict_wr_addr", N), last_wr_addr, 32'h300);
            chk($sformatf("N%0d_evict_wr_data", N), last_wr_data, 32'h10663040);
            do_read(32'h400, v);
            chk($sformatf("N%0d_evict_pending_lane", N), {24'h0, v}, 32'h77);
            do_flush();

            preload(32'h500, 32'h01020304);
            do_write(32'h502, 8'h99, 0, 0);
            w0 = n_wr;
            do_read(32'h502, v);
            chk($sformatf("N%0d_overlay_rd_hit", N), {24'h0, v}, 32'h99);
            do_read(32'h503, v);
            chk($sformatf("N%0d_overlay_rd_miss", N), {24'h0, v}, 32'h04);
            chk($sformatf("N%0d_overlay_no_wr", N), n_wr - w0, 0);
            do_flush();

            for (int i = 0; i < 60; i++) begin
                case ($urandom_range(0, 3))
                    0:       a = 32'h700;
                    1:       a = 32'h704;
                    2:       a = 32'h800;
                    default: a = 32'h900;
                endcase
                a = a | $urandom_range(0, 3);
                op = $urandom_range(0, 9);
                if (op < 6)      do_write(a, 8'($urandom), $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0);
                else if (op < 9) do_read(a, v);
                else             do_flush();
            end
            do_flush();

            do_write(32'h600, 8'hC7, 0, 0);
            w0 = n_wr;
            @(posedge clk); #1;
            flush = 1;
            exp_q.push_back('{is_wr: 1'b0, addr: 32'h600, data: 32'h0});
            @(posedge clk); #1;
            flush = 0;
            @(posedge clk); #1;
            reset_n = 0;
            @(negedge clk);
            chk_reset_outputs("midrmw");
            @(posedge clk); #1;
            reset_n = 1;
            for (int k = 0; k < 4; k++) rb_valid[k] = 0;
            repeat (N + 6) @(negedge clk);
            chk($sformatf("N%0d_midrmw_no_wr", N), n_wr - w0, 0);
            iw = init_word(30'h180);
            do_read(32'h600, v);
            chk($sformatf("N%0d_midrmw_buf_empty", N), {24'h0, v}, {24'h0, iw[31:24]});
            repeat (3) @(negedge clk);
            chk($sformatf("N%0d_exp_q_drained", N), exp_q.size(), 0);
            chk($sformatf("N%0d_rd_q_drained", N), rd_q.size(), 0);
            done_cnt++;
        end
    end

    initial begin
        for (int i = 0; i < 60000 && done_cnt < 3; i++) @(posedge clk);
        if (done_cnt < 3) begin
            checks++;
            failures++;
            $display("FAIL timeout: done %0d expected 3", done_cnt);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
